fetch_stage: RTL

- Instruction fetch front end of the pipelined CPU.
- Holds the PC and issues one request at a time to instruction memory.
- Captures the returned instruction into the IF/ID register and presents the opcode field `id_op` to the main decoder.
- Handles decode stalls, and branch/jump redirects from EX with kill of in-flight fetches.

---
 rtl/fetch_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, one outstanding imem request, IF/ID register with skid.
// Define FETCH_PERF_EN to add saturating perf_fetch / perf_kill counters.
module fetch_stage #(
  parameter int          IW       = 16,
  parameter int          AW       = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_valid,
  input  logic          stall_id,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  output logic [IW-1:0] id_instr,
  output logic [3:0]    id_op,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch,
  output logic [15:0]   perf_kill
`endif
);

  localparam logic [AW-1:0] ResetPc = AW'(RESET_PC);
  localparam logic [AW-1:0] PcOne   = AW'(1);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    STALL
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          kill_q, kill_d;
  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic          id_valid_q, id_valid_d;
  logic [IW-1:0] id_instr_q, id_instr_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic [AW-1:0] id_pc_plus1_q, id_pc_plus1_d;

  logic          load;
  logic [IW-1:0] load_instr;
  logic [AW-1:0] load_pc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus1_d = id_pc_plus1_q;
    load          = 1'b0;
    load_instr    = imem_rdata;
    load_pc       = pc_q;

    case (state_q)
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else if (!stall_id || !id_valid_q) begin
            load    = 1'b1;
            pc_d    = pc_q + PcOne;
            state_d = ISSUE;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = STALL;
          end
        end
      end
      STALL: begin
        if (!stall_id) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          pc_d       = pc_q + PcOne;
          state_d    = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase

    // The decoder takes the current instruction on any unstalled cycle.
    if (!stall_id) begin
      id_valid_d = 1'b0;
    end
    if (load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = load_instr;
      id_pc_d       = load_pc;
      id_pc_plus1_d = load_pc + PcOne;
    end

    // Redirect wins over everything: flush IF/ID and the skid, retarget the PC.
    if (redirect_en) begin
      pc_d          = redirect_pc;
      id_valid_d    = 1'b0;
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      id_pc_plus1_d = id_pc_plus1_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;
      case (state_q)
        ISSUE: begin
          state_d = WAIT;
          kill_d  = 1'b1;
        end
        WAIT: begin
          if (imem_valid) begin
            state_d = ISSUE;
            kill_d  = 1'b0;
          end else begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end
        default: begin
          state_d = ISSUE;
          kill_d  = 1'b0;
        end
      endcase
    end

    req_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ISSUE;
      req_q         <= 1'b1;
      pc_q          <= ResetPc;
      kill_q        <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus1_q <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus1_q <= id_pc_plus1_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_op       = id_instr_q[IW-1:IW-4];
  assign id_pc       = id_pc_q;
  assign id_pc_plus1 = id_pc_plus1_q;

`ifdef FETCH_PERF_EN
  logic        fetch_inc;
  logic        kill_inc;
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_kill_q;

  // A kill event is any response or skid entry that will never reach IF/ID.
  assign fetch_inc = load && !redirect_en;
  assign kill_inc  = ((state_q == WAIT) && imem_valid && (kill_q || redirect_en)) ||
                     ((state_q == STALL) && redirect_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      if (fetch_inc && (perf_fetch_q != 16'hFFFF)) begin
        perf_fetch_q <= perf_fetch_q + 16'd1;
      end
      if (kill_inc && (perf_kill_q != 16'hFFFF)) begin
        perf_kill_q <= perf_kill_q + 16'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_kill  = perf_kill_q;
`endif

endmodule
